// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file.
//   DATA_WIDTH / NUM_REG : default architectural sizes (RV32I)
//   IDX_W                : register index width
//   ZERO_REG             : index of the hardwired-zero register
//   reg_idx_t / xlen_t   : register index and register value types
package regfile_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REG    = 32;
  localparam int IDX_W      = $clog2(NUM_REG);
  localparam int ZERO_REG   = 0;

  typedef logic [IDX_W-1:0]      reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] xlen_t;
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bundle of all non-clock/reset signals of regfile_sb.
//   rd_addr / rd_data / rd_ready : NUM_RD read ports (Decode)
//   wr_en / wr_addr / wr_data    : NUM_WR write ports (Writeback)
//   iss_en / iss_rd              : destination issued this cycle
//   flush                        : squash all in-flight destinations
//   busy                         : scoreboard vector, bit 0 always 0
// Signalling: there is no valid/ready handshake. Every input is sampled on
// every rising edge; wr_en and iss_en qualify their own payloads for that
// cycle only. rd_ready is not a flow-control signal: it only states that
// the value on rd_data is architecturally final.
// master = Decode/Writeback side, slave = register file.
interface regfile_sb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REG    = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int IDX_W      = $clog2(NUM_REG)
) ();
  logic [NUM_RD-1:0][IDX_W-1:0]      rd_addr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]                 rd_ready;
  logic [NUM_WR-1:0]                 wr_en;
  logic [NUM_WR-1:0][IDX_W-1:0]      wr_addr;
  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wr_data;
  logic                              iss_en;
  logic [IDX_W-1:0]                  iss_rd;
  logic                              flush;
  logic [NUM_REG-1:0]                busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, flush,
    input  rd_data, rd_ready, busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, flush,
    output rd_data, rd_ready, busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy bit per register, tracking in-flight destinations.
//   clk, rst_n        : clock, asynchronous active-low reset
//   iss_en, iss_rd    : set busy for the issued destination
//   flush             : clear every busy bit (overrides issue)
//   wr_en, wr_addr    : writebacks clear busy for their destination
//   busy              : scoreboard vector, bit 0 constant 0
module regfile_scoreboard #(
  parameter int NUM_REG = 32,
  parameter int NUM_WR  = 1,
  parameter int IDX_W   = $clog2(NUM_REG)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         iss_en,
  input  logic [IDX_W-1:0]             iss_rd,
  input  logic                         flush,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR-1:0][IDX_W-1:0] wr_addr,
  output logic [NUM_REG-1:0]           busy
);
  import regfile_pkg::ZERO_REG;

  logic [NUM_REG-1:0] busy_q;
  logic [NUM_REG-1:0] busy_nxt;
  logic               wb_hit;

  always_comb begin
    busy_nxt = busy_q;
    wb_hit   = 1'b0;
    for (int r = 0; r < NUM_REG; r++) begin
      wb_hit = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w] == IDX_W'(r))) wb_hit = 1'b1;
      end
      // A new writer wins over a same-cycle writeback of the old one.
      if (flush)                                busy_nxt[r] = 1'b0;
      else if (iss_en && (iss_rd == IDX_W'(r))) busy_nxt[r] = 1'b1;
      else if (wb_hit)                          busy_nxt[r] = 1'b0;
    end
    busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  assign busy = busy_q;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with write-first bypass and a
// busy-bit scoreboard for RAW hazard detection in Decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : regfile_sb_if.slave (read ports, write ports, issue, flush,
//                busy vector)
// x0 reads as zero, is never busy and ignores writes and issues.
// Among several write ports hitting one register, the highest index wins.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REG    = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int IDX_W      = $clog2(NUM_REG)
) (
  input logic        clk,
  input logic        rst_n,
  regfile_sb_if.slave bus
);
  import regfile_pkg::ZERO_REG;

  logic [NUM_REG-1:0][DATA_WIDTH-1:0] mem;
  // Per-register resolved write: hit flag and winning data this cycle.
  logic [NUM_REG-1:0]                 wr_hit;
  logic [NUM_REG-1:0][DATA_WIDTH-1:0] wr_val;
  logic [NUM_REG-1:0]                 busy_vec;

  always_comb begin
    wr_hit = '0;
    wr_val = '0;
    for (int r = 1; r < NUM_REG; r++) begin
      // Ascending scan: a later (higher-index) port overrides earlier ones.
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && (bus.wr_addr[w] == IDX_W'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = bus.wr_data[w];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else begin
      for (int r = 1; r < NUM_REG; r++) begin
        if (wr_hit[r]) mem[r] <= wr_val[r];
      end
    end
  end

  regfile_scoreboard #(
    .NUM_REG (NUM_REG),
    .NUM_WR  (NUM_WR),
    .IDX_W   (IDX_W)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .iss_en  (bus.iss_en),
    .iss_rd  (bus.iss_rd),
    .flush   (bus.flush),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .busy    (busy_vec)
  );

  assign bus.busy = busy_vec;

  // Read ports. During reset the bypass is gated so reads return 0/ready.
  // The busy check uses the registered vector, so a same-cycle issue does
  // not affect readiness until the following cycle.
  always_comb begin
    bus.rd_data  = '0;
    bus.rd_ready = '1;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rst_n && (bus.rd_addr[p] != IDX_W'(ZERO_REG))) begin
        if (wr_hit[bus.rd_addr[p]]) bus.rd_data[p] = wr_val[bus.rd_addr[p]];
        else                        bus.rd_data[p] = mem[bus.rd_addr[p]];
        bus.rd_ready[p] = !busy_vec[bus.rd_addr[p]] || wr_hit[bus.rd_addr[p]];
      end
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized checks of regfile_sb (2 read,
// 2 write ports) against a behavioural model of the register file.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int N_RD = 2;
  localparam int N_WR = 2;

  logic clk;
  logic rst_n;

  regfile_sb_if #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REG    (NUM_REG),
    .NUM_RD     (N_RD),
    .NUM_WR     (N_WR),
    .IDX_W      (IDX_W)
  ) bus ();

  regfile_sb #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REG    (NUM_REG),
    .NUM_RD     (N_RD),
    .NUM_WR     (N_WR),
    .IDX_W      (IDX_W)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  xlen_t              m_regs [NUM_REG];
  logic [NUM_REG-1:0] m_busy;

  int n_pass  = 0;
  int n_total = 0;

  task automatic model_clear();
    for (int i = 0; i < NUM_REG; i++) m_regs[i] = '0;
    m_busy = '0;
  endtask

  // Expected read result from the architectural rules.
  task automatic model_read(input int a, output xlen_t d, output logic rdy);
    d   = m_regs[a];
    rdy = !m_busy[a];
    for (int w = 0; w < N_WR; w++) begin
      if (bus.wr_en[w] && int'(bus.wr_addr[w]) == a) begin
        d   = bus.wr_data[w];
        rdy = 1'b1;
      end
    end
    if (a == 0 || !rst_n) begin
      d   = '0;
      rdy = 1'b1;
    end
  endtask

  // State change at a rising edge given the inputs of that cycle.
  task automatic model_edge();
    logic [NUM_REG-1:0] cleared;
    cleared = '0;
    if (!rst_n) return;
    for (int w = 0; w < N_WR; w++) begin
      if (bus.wr_en[w] && bus.wr_addr[w] != 0) begin
        m_regs[bus.wr_addr[w]] = bus.wr_data[w];
        cleared[bus.wr_addr[w]] = 1'b1;
      end
    end
    if (bus.flush) begin
      m_busy = '0;
    end else begin
      m_busy = m_busy & ~cleared;
      if (bus.iss_en && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    xlen_t d;
    logic  r;
    for (int p = 0; p < N_RD; p++) begin
      model_read(int'(bus.rd_addr[p]), d, r);
      chk($sformatf("%s.rd_data%0d", tag, p), bus.rd_data[p], d);
      chk($sformatf("%s.rd_ready%0d", tag, p), 32'(bus.rd_ready[p]), 32'(r));
    end
    chk($sformatf("%s.busy", tag), bus.busy, m_busy);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are driven at the falling edge; step() checks just after that,
  // then lets one rising edge happen and lands on the next falling edge.
  task automatic idle();
    bus.wr_en   = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.iss_en  = 1'b0;
    bus.iss_rd  = '0;
    bus.flush   = 1'b0;
  endtask

  task automatic drive_wr(input int port, input int a, input xlen_t d);
    bus.wr_en[port]   = 1'b1;
    bus.wr_addr[port] = reg_idx_t'(a);
    bus.wr_data[port] = d;
  endtask

  task automatic drive_rd(input int a0, input int a1);
    bus.rd_addr[0] = reg_idx_t'(a0);
    bus.rd_addr[1] = reg_idx_t'(a1);
  endtask

  task automatic drive_iss(input int a);
    bus.iss_en = 1'b1;
    bus.iss_rd = reg_idx_t'(a);
  endtask

  task automatic step(input string tag);
    #1;
    check_outputs(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    drive_rd(0, 0);
    model_clear();
    @(negedge clk);

    // Reset held for two cycles; a write and an issue must be ignored.
    drive_wr(0, 1, 32'hAAAA_5555);
    drive_iss(2);
    step("rst_cyc0");
    step("rst_cyc1");
    idle();
    for (int a = 0; a < NUM_REG; a++) begin
      drive_rd(a, NUM_REG - 1 - a);
      #0.1;
      chk("rst_read_data", bus.rd_data[0], 32'h0);
      chk("rst_read_ready", 32'(bus.rd_ready[0]), 32'h1);
    end
    chk("rst_busy", bus.busy, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    drive_rd(1, 2);
    step("post_rst_ignored");
    chk("x1_not_written_in_rst", bus.rd_data[0], 32'h0);

    // x0 is hardwired zero and never busy.
    drive_wr(0, 0, 32'h1234);
    drive_iss(0);
    drive_rd(0, 0);
    step("x0_write");
    idle();
    step("x0_read");
    chk("x0_read_zero", bus.rd_data[0], 32'h0);
    chk("x0_busy_zero", 32'(bus.busy[0]), 32'h0);

    // Write-first bypass on port 1, then the stored value.
    drive_wr(0, 7, 32'hCAFE_F00D);
    drive_rd(0, 7);
    #1;
    chk("x7_bypass", bus.rd_data[1], 32'hCAFE_F00D);
    step("x7_write");
    idle();
    #1;
    chk("x7_stored", bus.rd_data[1], 32'hCAFE_F00D);
    step("x7_read");

    // Issue x3 -> not ready; writeback makes it ready through the bypass.
    drive_iss(3);
    drive_rd(3, 0);
    #1;
    chk("x3_ready_same_cycle", 32'(bus.rd_ready[0]), 32'h1);
    step("x3_issue");
    idle();
    #1;
    chk("x3_not_ready", 32'(bus.rd_ready[0]), 32'h0);
    step("x3_wait");
    drive_wr(1, 3, 32'h55);
    #1;
    chk("x3_wb_ready", 32'(bus.rd_ready[0]), 32'h1);
    chk("x3_wb_data", bus.rd_data[0], 32'h55);
    step("x3_wb");
    idle();
    #1;
    chk("x3_busy_cleared", 32'(bus.busy[3]), 32'h0);
    step("x3_after");

    // Issue and writeback to x9 together: the new writer wins.
    drive_iss(9);
    drive_wr(0, 9, 32'h99);
    drive_rd(9, 10);
    step("x9_iss_wb");
    idle();
    #1;
    chk("x9_busy_set", 32'(bus.busy[9]), 32'h1);
    step("x9_busy");
    // Flush overrides a same-cycle issue.
    bus.flush = 1'b1;
    drive_iss(10);
    step("flush_iss");
    idle();
    #1;
    chk("flush_busy_all", bus.busy, 32'h0);
    step("after_flush");

    // Two write ports on x4: the higher port wins.
    drive_wr(0, 4, 32'h1);
    drive_wr(1, 4, 32'h2);
    drive_rd(4, 4);
    #1;
    chk("x4_prio_bypass", bus.rd_data[0], 32'h2);
    step("x4_dual");
    idle();
    #1;
    chk("x4_prio_stored", bus.rd_data[1], 32'h2);
    step("x4_read");

    // Randomized traffic, addresses biased to a small window for conflicts.
    for (int i = 0; i < 400; i++) begin
      idle();
      for (int w = 0; w < N_WR; w++) begin
        if ($urandom_range(0, 2) == 0) drive_wr(w, $urandom_range(0, 7), $urandom);
      end
      if ($urandom_range(0, 1) == 0) drive_iss($urandom_range(0, 7));
      bus.flush = ($urandom_range(0, 15) == 0);
      drive_rd($urandom_range(0, 7), $urandom_range(0, NUM_REG - 1));
      step("rand");
    end

    // Asynchronous reset mid-run clears storage without a clock edge.
    idle();
    drive_wr(0, 5, 32'hDEAD_BEEF);
    drive_iss(6);
    step("x5_write");
    idle();
    drive_rd(5, 6);
    #1;
    chk("x5_before_rst", bus.rd_data[0], 32'hDEAD_BEEF);
    chk("x6_busy_before_rst", 32'(bus.busy[6]), 32'h1);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("x5_in_rst", bus.rd_data[0], 32'h0);
    chk("x6_ready_in_rst", 32'(bus.rd_ready[1]), 32'h1);
    chk("busy_in_rst", bus.busy, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("x5_cleared", bus.rd_data[0], 32'h0);
    step("after_async_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
